// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between the fetch stage (read-only)
// and the memory stage (read/write). Memory stage has fixed priority; each access holds the
// port enabled for WAIT_CYCLES cycles, then spends one DONE cycle before returning to IDLE.
module mem_port_arbiter #(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [WORD_WIDTH-1:0] if_rdata,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  mem_ready,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_wdata,
  input  logic [WORD_WIDTH-1:0] sram_rdata,
  output logic                  if_freeze,
  output logic                  mem_freeze,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIf, OwnMem} owner_e;

  // Counter is 4 bits wide, enough for WAIT_CYCLES up to 15.
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic grant_mem, grant_if, access_last;

  logic                  en_q, we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WORD_WIDTH-1:0] if_rdata_q, mem_rdata_q;

  // State, owner and wait-counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: fixed-priority grant in IDLE, count down in ACCESS, single DONE cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          grant_mem = 1'b1;
          owner_d   = OwnMem;
          cnt_d     = WaitLoad;
          state_d   = StAccess;
        end else if (if_req) begin
          grant_if = 1'b1;
          owner_d  = OwnIf;
          cnt_d    = WaitLoad;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
    endcase
  end

  assign access_last = (state_q == StAccess) && (cnt_q == 4'd0);

  // Memory port registers and read-data capture; the port is never aborted mid-access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else if (grant_mem) begin
      en_q    <= 1'b1;
      we_q    <= mem_we;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end else if (grant_if) begin
      en_q   <= 1'b1;
      we_q   <= 1'b0;
      addr_q <= if_addr;
    end else if (access_last) begin
      en_q <= 1'b0;
      we_q <= 1'b0;
      // Fetch data is captured even if the request was withdrawn meanwhile.
      if (owner_q == OwnIf) begin
        if_rdata_q <= sram_rdata;
      end else if ((owner_q == OwnMem) && !we_q) begin
        mem_rdata_q <= sram_rdata;
      end
    end
  end

  // Outputs: ready pulses only to a still-requesting owner in DONE; freezes follow.
  always_comb begin
    if_ready   = (state_q == StDone) && (owner_q == OwnIf) && if_req;
    mem_ready  = (state_q == StDone) && (owner_q == OwnMem) && mem_req;
    if_freeze  = if_req & ~if_ready;
    mem_freeze = mem_req & ~mem_ready;
    busy       = (state_q != StIdle);
    sram_en    = en_q;
    sram_we    = we_q;
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    if_rdata   = if_rdata_q;
    mem_rdata  = mem_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT_CYCLES 3 and 1) share directed stimulus; a
// time-based transaction model predicts every output each cycle, and literal checks pin timing.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;

  logic        if_ready[2], mem_ready[2], sram_en[2], sram_we[2];
  logic        if_freeze[2], mem_freeze[2], busy[2];
  logic [31:0] if_rdata[2], mem_rdata[2], sram_addr[2], sram_wdata[2], sram_rdata[2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready[0]), .if_rdata(if_rdata[0]),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]),
    .sram_en(sram_en[0]), .sram_we(sram_we[0]), .sram_addr(sram_addr[0]),
    .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]),
    .if_freeze(if_freeze[0]), .mem_freeze(mem_freeze[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready[1]), .if_rdata(if_rdata[1]),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]),
    .sram_en(sram_en[1]), .sram_we(sram_we[1]), .sram_addr(sram_addr[1]),
    .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]),
    .if_freeze(if_freeze[1]), .mem_freeze(mem_freeze[1]), .busy(busy[1])
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  // Transaction model: one access granted at cycle t0 occupies t0+1..t0+W+1.
  bit          m_busy[2];
  int          m_t0[2];
  int          m_owner[2];  // 0 none, 1 fetch, 2 memory stage
  bit          m_we[2];
  logic [31:0] m_addr[2], m_wdata[2], m_if_rdata[2], m_mem_rdata[2];

  // Observations recorded per test.
  int if_rdy_n[2], if_rdy_c0[2], if_rdy_c1[2];
  int mem_rdy_n[2], mem_rdy_c0[2];
  int en_c0[2], wr_cnt[2];

  function automatic int wait_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'hE3A0_1005;
      32'h0000_0400: return 32'h0000_002A;
      default:       return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endcase
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Advance the model across the edge that ends cycle 'cyc', using that cycle's inputs.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_busy[k] = 1'b0; m_owner[k] = 0; m_we[k] = 1'b0;
        m_addr[k] = '0; m_wdata[k] = '0; m_if_rdata[k] = '0; m_mem_rdata[k] = '0;
      end else if (!m_busy[k]) begin
        if (mem_req) begin
          m_busy[k] = 1'b1; m_t0[k] = cyc; m_owner[k] = 2;
          m_we[k] = mem_we; m_addr[k] = mem_addr; m_wdata[k] = mem_wdata;
        end else if (if_req) begin
          m_busy[k] = 1'b1; m_t0[k] = cyc; m_owner[k] = 1;
          m_we[k] = 1'b0; m_addr[k] = if_addr;
        end
      end else begin
        if (cyc == m_t0[k] + wait_of(k)) begin
          if (m_owner[k] == 1) m_if_rdata[k] = mem_word(m_addr[k]);
          else if (!m_we[k]) m_mem_rdata[k] = mem_word(m_addr[k]);
        end
        if (cyc == m_t0[k] + wait_of(k) + 1) m_busy[k] = 1'b0;
      end
    end
  endtask

  // Memory only presents true data in the last enabled cycle; garbage otherwise.
  task automatic drive_rdata();
    for (int k = 0; k < 2; k++) begin
      if (m_busy[k] && (cyc == m_t0[k] + wait_of(k))) sram_rdata[k] = mem_word(m_addr[k]);
      else sram_rdata[k] = ~mem_word(m_addr[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    drive_rdata();
  endtask

  task automatic clear_rec();
    for (int k = 0; k < 2; k++) begin
      if_rdy_n[k] = 0; if_rdy_c0[k] = -1; if_rdy_c1[k] = -1;
      mem_rdy_n[k] = 0; mem_rdy_c0[k] = -1; en_c0[k] = -1; wr_cnt[k] = 0;
    end
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 60; i++) begin
      if (!m_busy[0] && !m_busy[1]) return;
      tick();
    end
    n_vec++;
    n_bad++;
    $display("FAIL wait_quiet timeout cycle %0d: got busy, expected idle", cyc);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        bit en_e, done_e, ifr_e, memr_e;
        en_e   = m_busy[k] && (cyc >= m_t0[k] + 1) && (cyc <= m_t0[k] + wait_of(k));
        done_e = m_busy[k] && (cyc == m_t0[k] + wait_of(k) + 1);
        ifr_e  = done_e && (m_owner[k] == 1) && if_req;
        memr_e = done_e && (m_owner[k] == 2) && mem_req;
        check("sram_en", k, 32'(sram_en[k]), 32'(en_e));
        check("sram_we", k, 32'(sram_we[k]), 32'(en_e && m_we[k]));
        check("sram_addr", k, sram_addr[k], m_addr[k]);
        if (m_owner[k] == 2 || !rst) check("sram_wdata", k, sram_wdata[k], m_wdata[k]);
        check("if_ready", k, 32'(if_ready[k]), 32'(ifr_e));
        check("mem_ready", k, 32'(mem_ready[k]), 32'(memr_e));
        check("if_freeze", k, 32'(if_freeze[k]), 32'(if_req && !ifr_e));
        check("mem_freeze", k, 32'(mem_freeze[k]), 32'(mem_req && !memr_e));
        check("busy", k, 32'(busy[k]), 32'(m_busy[k]));
        check("if_rdata", k, if_rdata[k], m_if_rdata[k]);
        check("mem_rdata", k, mem_rdata[k], m_mem_rdata[k]);
        if (if_ready[k]) begin
          if_rdy_n[k]++;
          if (if_rdy_n[k] == 1) if_rdy_c0[k] = cyc;
          if (if_rdy_n[k] == 2) if_rdy_c1[k] = cyc;
        end
        if (mem_ready[k]) begin
          mem_rdy_n[k]++;
          if (mem_rdy_n[k] == 1) mem_rdy_c0[k] = cyc;
        end
        if (sram_en[k] && en_c0[k] < 0) en_c0[k] = cyc;
        if (sram_we[k] && sram_addr[k] == 32'h404 && sram_wdata[k] == 32'hDEAD_BEEF) wr_cnt[k]++;
      end
    end
  end

  initial begin
    int t;
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    sram_rdata[0] = '0; sram_rdata[1] = '0;
    clear_rec();

    // Reset
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", k, 32'(busy[k]), 32'd0);
      check("rst_sram_en", k, 32'(sram_en[k]), 32'd0);
      check("rst_if_rdata", k, if_rdata[k], 32'd0);
      check("rst_sram_addr", k, sram_addr[k], 32'd0);
    end
    tick();

    // Single fetch held through cycle t+5
    clear_rec();
    t = cyc; if_req = 1'b1; if_addr = 32'h10;
    repeat (6) tick();
    if_req = 1'b0;
    wait_quiet();
    check("fetch_en_first_w3", 0, en_c0[0], t + 1);
    check("fetch_ready_w3", 0, if_rdy_c0[0], t + 4);
    check("fetch_pulses_w3", 0, if_rdy_n[0], 1);
    check("fetch_rdata_w3", 0, if_rdata[0], 32'hE3A0_1005);
    check("fetch_ready_w1", 1, if_rdy_c0[1], t + 2);
    check("fetch_b2b_w1", 1, if_rdy_c1[1], t + 5);
    check("fetch_rdata_w1", 1, if_rdata[1], 32'hE3A0_1005);

    // Contention: memory stage wins, fetch follows
    clear_rec();
    t = cyc; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400; if_req = 1'b1; if_addr = 32'h20;
    repeat (5) tick();
    mem_req = 1'b0;
    repeat (5) tick();
    if_req = 1'b0;
    wait_quiet();
    check("cont_mem_ready_w3", 0, mem_rdy_c0[0], t + 4);
    check("cont_mem_rdata_w3", 0, mem_rdata[0], 32'h0000_002A);
    check("cont_if_ready_w3", 0, if_rdy_c0[0], t + 9);
    check("cont_mem_ready_w1", 1, mem_rdy_c0[1], t + 2);

    // Write
    clear_rec();
    t = cyc; mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h404; mem_wdata = 32'hDEAD_BEEF;
    repeat (5) tick();
    mem_req = 1'b0; mem_we = 1'b0;
    wait_quiet();
    check("wr_ready_w3", 0, mem_rdy_c0[0], t + 4);
    check("wr_cycles_w3", 0, wr_cnt[0], 3);
    check("wr_rdata_kept_w3", 0, mem_rdata[0], 32'h0000_002A);
    check("wr_rdata_kept_w1", 1, mem_rdata[1], 32'h0000_002A);

    // Withdrawn fetch
    clear_rec();
    t = cyc; if_req = 1'b1; if_addr = 32'h30;
    repeat (2) tick();
    if_req = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("wd_busy_t5_w3", 0, 32'(busy[0]), 32'd0);
    wait_quiet();
    check("wd_no_ready_w3", 0, if_rdy_n[0], 0);
    check("wd_no_ready_w1", 1, if_rdy_n[1], 0);
    check("wd_rdata_w3", 0, if_rdata[0], mem_word(32'h30));

    // Reset during access, pending memory request granted afterwards
    clear_rec();
    t = cyc; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_en_w3", 0, 32'(sram_en[0]), 32'd0);
    check("rst_mid_busy_w3", 0, 32'(busy[0]), 32'd0);
    repeat (5) tick();
    mem_req = 1'b0;
    wait_quiet();
    check("rst_mid_ready_w3", 0, mem_rdy_c0[0], t + 7);
    check("rst_mid_pulses_w3", 0, mem_rdy_n[0], 1);
    check("rst_mid_rdata_w3", 0, mem_rdata[0], mem_word(32'h500));

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
